// File: rtl/bus_host_arbiter_pkg.sv
// rtl/bus_host_arbiter_pkg.sv - shared types for the host/device bus arbiter
package bus_host_arbiter_pkg;

    typedef enum logic {
        FixedPrio  = 1'b0,
        RoundRobin = 1'b1
    } bus_arb_mode_e;

    // Index fields are sized for up to 16 hosts / 16 devices.
    localparam int unsigned MaxIdxW = 4;

    typedef struct packed {
        logic               valid;
        logic [MaxIdxW-1:0] host;
        logic [MaxIdxW-1:0] dev;
        logic               unmapped;
    } rsp_tag_t;

endpackage

// File: rtl/bus_host_arbiter_if.sv
// rtl/bus_host_arbiter_if.sv - host, device and config signals of the shared bus
interface bus_host_arbiter_if #(
    parameter int unsigned NrHosts      = 3,
    parameter int unsigned NrDevices    = 2,
    parameter int unsigned DataWidth    = 32,
    parameter int unsigned AddressWidth = 32
);
    logic                      host_req_i             [NrHosts];
    logic                      host_gnt_o             [NrHosts];
    logic [AddressWidth-1:0]   host_addr_i            [NrHosts];
    logic                      host_we_i              [NrHosts];
    logic [DataWidth/8-1:0]    host_be_i              [NrHosts];
    logic [DataWidth-1:0]      host_wdata_i           [NrHosts];
    logic                      host_rvalid_o          [NrHosts];
    logic [DataWidth-1:0]      host_rdata_o           [NrHosts];
    logic                      host_err_o             [NrHosts];

    logic                      device_req_o           [NrDevices];
    logic [AddressWidth-1:0]   device_addr_o          [NrDevices];
    logic                      device_we_o            [NrDevices];
    logic [DataWidth/8-1:0]    device_be_o            [NrDevices];
    logic [DataWidth-1:0]      device_wdata_o         [NrDevices];
    logic                      device_rvalid_i        [NrDevices];
    logic [DataWidth-1:0]      device_rdata_i         [NrDevices];
    logic                      device_err_i           [NrDevices];

    logic [AddressWidth-1:0]   cfg_device_addr_base_i [NrDevices];
    logic [AddressWidth-1:0]   cfg_device_addr_mask_i [NrDevices];
    logic                      busy_o;

    modport master (
        output host_req_i, host_addr_i, host_we_i, host_be_i, host_wdata_i,
        output device_rvalid_i, device_rdata_i, device_err_i,
        output cfg_device_addr_base_i, cfg_device_addr_mask_i,
        input  host_gnt_o, host_rvalid_o, host_rdata_o, host_err_o,
        input  device_req_o, device_addr_o, device_we_o, device_be_o, device_wdata_o,
        input  busy_o
    );

    modport slave (
        input  host_req_i, host_addr_i, host_we_i, host_be_i, host_wdata_i,
        input  device_rvalid_i, device_rdata_i, device_err_i,
        input  cfg_device_addr_base_i, cfg_device_addr_mask_i,
        output host_gnt_o, host_rvalid_o, host_rdata_o, host_err_o,
        output device_req_o, device_addr_o, device_we_o, device_be_o, device_wdata_o,
        output busy_o
    );

endinterface

// File: rtl/bus_host_arbiter_rr_arb.sv
// rtl/bus_host_arbiter_rr_arb.sv - combinational fixed-priority / round-robin picker
module bus_rr_arb
    import bus_host_arbiter_pkg::*;
#(
    parameter int unsigned   N    = 3,
    parameter bus_arb_mode_e Mode = FixedPrio
) (
    input  logic [N-1:0]       i_req,
    input  logic [MaxIdxW-1:0] i_ptr,
    output logic [N-1:0]       o_gnt,
    output logic [MaxIdxW-1:0] o_idx,
    output logic               o_valid
);

    logic [MaxIdxW-1:0] w_start;
    logic [N-1:0]       w_rot;

    function automatic logic [MaxIdxW-1:0] wrap_idx(input logic [MaxIdxW-1:0] s,
                                                    input int unsigned k);
        int unsigned v;
        v = 32'(s) + k;
        if (v >= N) v = v - N;
        return MaxIdxW'(v);
    endfunction

    // Requests are rotated so the search always starts at bit 0 of w_rot.
    always_comb begin
        w_start = '0;
        if (Mode == RoundRobin && i_ptr < MaxIdxW'(N-1)) w_start = i_ptr + 1'b1;
        w_rot   = N'({i_req, i_req} >> w_start);
        o_valid = 1'b0;
        o_idx   = '0;
        o_gnt   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (!o_valid && w_rot[k]) begin
                o_valid = 1'b1;
                o_idx   = wrap_idx(w_start, k);
            end
        end
        for (int unsigned h = 0; h < N; h++) begin
            o_gnt[h] = o_valid && (o_idx == MaxIdxW'(h));
        end
    end

endmodule

// File: rtl/bus_host_arbiter.sv
// rtl/bus_host_arbiter.sv - single-issue shared-bus arbiter with address decode
// and one-cycle response routing back to the requesting host
module bus_host_arbiter
    import bus_host_arbiter_pkg::*;
#(
    parameter int unsigned NrHosts      = 3,
    parameter int unsigned NrDevices    = 2,
    parameter int unsigned DataWidth    = 32,
    parameter int unsigned AddressWidth = 32,
    parameter bit          RoundRobin   = 1'b0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    bus_host_arbiter_if.slave bus
);

    localparam bus_arb_mode_e ArbMode = RoundRobin ? bus_host_arbiter_pkg::RoundRobin
                                                   : bus_host_arbiter_pkg::FixedPrio;

    logic [NrHosts-1:0]       w_req;
    logic [NrHosts-1:0]       w_gnt;
    logic [MaxIdxW-1:0]       w_win;
    logic                     w_win_valid;
    logic [AddressWidth-1:0]  w_sel_addr;
    logic                     w_sel_we;
    logic [DataWidth/8-1:0]   w_sel_be;
    logic [DataWidth-1:0]     w_sel_wdata;
    logic                     w_mapped;
    logic [MaxIdxW-1:0]       w_dev;
    logic [NrDevices-1:0]     w_dev_sel;
    logic [DataWidth-1:0]     w_rsp_rdata;
    logic                     w_rsp_err;
    logic                     w_rsp_dvalid;

    logic [MaxIdxW-1:0]       r_rr_ptr;
    rsp_tag_t                 r_rsp;

    // Gating with reset keeps grants and device requests low while reset is held.
    always_comb begin
        for (int unsigned h = 0; h < NrHosts; h++) begin
            w_req[h] = bus.host_req_i[h] & rst_ni;
        end
    end

    bus_rr_arb #(
        .N    (NrHosts),
        .Mode (ArbMode)
    ) u_arb (
        .i_req   (w_req),
        .i_ptr   (r_rr_ptr),
        .o_gnt   (w_gnt),
        .o_idx   (w_win),
        .o_valid (w_win_valid)
    );

    always_comb begin
        w_sel_addr  = '0;
        w_sel_we    = 1'b0;
        w_sel_be    = '0;
        w_sel_wdata = '0;
        for (int unsigned h = 0; h < NrHosts; h++) begin
            bus.host_gnt_o[h] = w_gnt[h];
            if (w_gnt[h]) begin
                w_sel_addr  = bus.host_addr_i[h];
                w_sel_we    = bus.host_we_i[h];
                w_sel_be    = bus.host_be_i[h];
                w_sel_wdata = bus.host_wdata_i[h];
            end
        end
    end

    // Lowest matching device index wins when address windows overlap.
    always_comb begin
        w_mapped = 1'b0;
        w_dev    = '0;
        for (int unsigned d = 0; d < NrDevices; d++) begin
            if (!w_mapped &&
                ((w_sel_addr & bus.cfg_device_addr_mask_i[d]) == bus.cfg_device_addr_base_i[d])) begin
                w_mapped = 1'b1;
                w_dev    = MaxIdxW'(d);
            end
        end
        for (int unsigned d = 0; d < NrDevices; d++) begin
            w_dev_sel[d] = w_win_valid && w_mapped && (w_dev == MaxIdxW'(d));
        end
    end

    always_comb begin
        for (int unsigned d = 0; d < NrDevices; d++) begin
            bus.device_req_o[d]   = w_dev_sel[d];
            bus.device_addr_o[d]  = w_dev_sel[d] ? w_sel_addr  : '0;
            bus.device_we_o[d]    = w_dev_sel[d] & w_sel_we;
            bus.device_be_o[d]    = w_dev_sel[d] ? w_sel_be    : '0;
            bus.device_wdata_o[d] = w_dev_sel[d] ? w_sel_wdata : '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rsp    <= '0;
            r_rr_ptr <= MaxIdxW'(NrHosts - 1);
        end else begin
            r_rsp.valid    <= w_win_valid;
            r_rsp.host     <= w_win;
            r_rsp.dev      <= w_dev;
            r_rsp.unmapped <= ~w_mapped;
            if (w_win_valid) r_rr_ptr <= w_win;
        end
    end

    always_comb begin
        w_rsp_rdata  = '0;
        w_rsp_err    = 1'b0;
        w_rsp_dvalid = 1'b0;
        for (int unsigned d = 0; d < NrDevices; d++) begin
            if (r_rsp.dev == MaxIdxW'(d)) begin
                w_rsp_rdata  = bus.device_rdata_i[d];
                w_rsp_err    = bus.device_err_i[d];
                w_rsp_dvalid = bus.device_rvalid_i[d];
            end
        end
        if (r_rsp.unmapped) begin
            w_rsp_rdata = '0;
            w_rsp_err   = 1'b1;
        end
    end

    always_comb begin
        for (int unsigned h = 0; h < NrHosts; h++) begin
            bus.host_rvalid_o[h] = r_rsp.valid && (r_rsp.host == MaxIdxW'(h));
            bus.host_rdata_o[h]  = bus.host_rvalid_o[h] ? w_rsp_rdata : '0;
            bus.host_err_o[h]    = bus.host_rvalid_o[h] & w_rsp_err;
        end
    end

    assign bus.busy_o = r_rsp.valid;

    // Mapped devices must answer exactly one cycle after their request.
    a_dev_rsp: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (r_rsp.valid && !r_rsp.unmapped) |-> w_rsp_dvalid);

endmodule

// File: tb/tb_bus_host_arbiter.sv
// tb/tb_bus_host_arbiter.sv - directed bench for bus_host_arbiter (fixed and round-robin)
module tb_bus_host_arbiter;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    bus_host_arbiter_if #(.NrHosts(3), .NrDevices(2), .DataWidth(32), .AddressWidth(32)) ifa ();
    bus_host_arbiter_if #(.NrHosts(3), .NrDevices(2), .DataWidth(32), .AddressWidth(32)) ifb ();

    bus_host_arbiter #(
        .NrHosts(3), .NrDevices(2), .DataWidth(32), .AddressWidth(32), .RoundRobin(1'b0)
    ) dut_a (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (ifa)
    );

    bus_host_arbiter #(
        .NrHosts(3), .NrDevices(2), .DataWidth(32), .AddressWidth(32), .RoundRobin(1'b1)
    ) dut_b (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (ifb)
    );

    // Device 0 word i holds 0xD000_0000+i, device 1 word i holds 0xD000_0100+i.
    logic [31:0] mem [2][256];

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            ifa.device_rvalid_i[d] <= ifa.device_req_o[d];
            ifa.device_rdata_i[d]  <= mem[d][ifa.device_addr_o[d][9:2]];
            ifa.device_err_i[d]    <= 1'b0;
            ifb.device_rvalid_i[d] <= ifb.device_req_o[d];
            ifb.device_rdata_i[d]  <= 32'h0;
            ifb.device_err_i[d]    <= 1'b0;
            if (!rst_n) begin
                for (int i = 0; i < 256; i++) mem[d][i] <= 32'hD000_0000 + 32'(d * 256 + i);
            end else if (ifa.device_req_o[d] && ifa.device_we_o[d]) begin
                for (int b = 0; b < 4; b++) begin
                    if (ifa.device_be_o[d][b])
                        mem[d][ifa.device_addr_o[d][9:2]][8*b +: 8] <= ifa.device_wdata_o[d][8*b +: 8];
                end
            end
        end
    end

    function automatic logic [2:0] pack3(input logic a [3]);
        logic [2:0] r;
        for (int i = 0; i < 3; i++) r[i] = a[i];
        return r;
    endfunction

    function automatic logic [1:0] pack2(input logic a [2]);
        logic [1:0] r;
        for (int i = 0; i < 2; i++) r[i] = a[i];
        return r;
    endfunction

    task automatic idle_all();
        for (int h = 0; h < 3; h++) begin
            ifa.host_req_i[h] = 1'b0;  ifa.host_addr_i[h] = '0; ifa.host_we_i[h] = 1'b0;
            ifa.host_be_i[h]  = 4'hF;  ifa.host_wdata_i[h] = '0;
            ifb.host_req_i[h] = 1'b0;  ifb.host_addr_i[h] = '0; ifb.host_we_i[h] = 1'b0;
            ifb.host_be_i[h]  = 4'hF;  ifb.host_wdata_i[h] = '0;
        end
    endtask

    task automatic test_reset();
        for (int h = 0; h < 3; h++) ifa.host_req_i[h] = 1'b1;
        ifb.host_req_i[0] = 1'b1;
        ifb.host_req_i[2] = 1'b1;
        repeat (2) @(negedge clk);
        n_total++; if (pack3(ifa.host_gnt_o) !== 3'b000)
            $display("FAIL reset_gnt: got %b, expected 000", pack3(ifa.host_gnt_o)); else n_pass++;
        n_total++; if (pack2(ifa.device_req_o) !== 2'b00)
            $display("FAIL reset_dev_req: got %b, expected 00", pack2(ifa.device_req_o)); else n_pass++;
        n_total++; if (pack3(ifa.host_rvalid_o) !== 3'b000 || ifa.busy_o !== 1'b0)
            $display("FAIL reset_rvalid_busy: got %b/%b, expected 000/0", pack3(ifa.host_rvalid_o), ifa.busy_o); else n_pass++;
        @(posedge clk); #1;
        for (int h = 0; h < 3; h++) ifa.host_req_i[h] = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        n_total++; if (pack3(ifb.host_gnt_o) !== 3'b001)
            $display("FAIL reset_rr_ptr: got %b, expected 001", pack3(ifb.host_gnt_o)); else n_pass++;
        n_total++; if (pack3(ifa.host_rvalid_o) !== 3'b000)
            $display("FAIL reset_no_stray: got %b, expected 000", pack3(ifa.host_rvalid_o)); else n_pass++;
        @(posedge clk); #1;
        ifb.host_req_i[0] = 1'b0;
        ifb.host_req_i[2] = 1'b0;
        ifa.host_req_i[0] = 1'b1;
        ifa.host_addr_i[0] = 32'h100;
        @(negedge clk);
        n_total++; if (pack3(ifa.host_gnt_o) !== 3'b001)
            $display("FAIL midrst_gnt: got %b, expected 001", pack3(ifa.host_gnt_o)); else n_pass++;
        @(posedge clk); #1;
        ifa.host_req_i[0] = 1'b0;
        n_total++; if (ifa.busy_o !== 1'b1)
            $display("FAIL midrst_busy: got %b, expected 1", ifa.busy_o); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_total++; if (pack3(ifa.host_rvalid_o) !== 3'b000 || ifa.busy_o !== 1'b0)
            $display("FAIL midrst_drop: got %b/%b, expected 000/0", pack3(ifa.host_rvalid_o), ifa.busy_o); else n_pass++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_total++; if (pack3(ifa.host_rvalid_o) !== 3'b000)
                $display("FAIL midrst_no_rvalid: got %b, expected 000", pack3(ifa.host_rvalid_o)); else n_pass++;
        end
    endtask

    task automatic test_fixed_priority();
        logic [2:0] exp_g;
        logic [2:0] exp_rv;
        @(posedge clk); #1;
        for (int h = 0; h < 3; h++) begin
            ifa.host_req_i[h]  = 1'b1;
            ifa.host_addr_i[h] = 32'h100 + 32'(4 * h);
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            exp_g  = (c < 3) ? 3'(1 << c) : 3'b000;
            exp_rv = (c > 0) ? 3'(1 << (c - 1)) : 3'b000;
            n_total++; if (pack3(ifa.host_gnt_o) !== exp_g)
                $display("FAIL fixed_gnt[%0d]: got %b, expected %b", c, pack3(ifa.host_gnt_o), exp_g); else n_pass++;
            n_total++; if (pack3(ifa.host_rvalid_o) !== exp_rv)
                $display("FAIL fixed_rvalid[%0d]: got %b, expected %b", c, pack3(ifa.host_rvalid_o), exp_rv); else n_pass++;
            if (c > 0) begin
                n_total++; if (ifa.host_rdata_o[c-1] !== 32'hD000_0040 + 32'(c - 1))
                    $display("FAIL fixed_rdata[%0d]: got %h, expected %h", c - 1, ifa.host_rdata_o[c-1], 32'hD000_0040 + 32'(c - 1)); else n_pass++;
            end
            @(posedge clk); #1;
            if (c < 3) ifa.host_req_i[c] = 1'b0;
        end
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_g [4] = '{3'b010, 3'b100, 3'b010, 3'b100};
        @(posedge clk); #1;
        ifb.host_req_i[1] = 1'b1;
        ifb.host_req_i[2] = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_total++; if (pack3(ifb.host_gnt_o) !== exp_g[c])
                $display("FAIL rr_gnt[%0d]: got %b, expected %b", c, pack3(ifb.host_gnt_o), exp_g[c]); else n_pass++;
            @(posedge clk); #1;
        end
        ifb.host_req_i[1] = 1'b0;
        ifb.host_req_i[2] = 1'b0;
    endtask

    task automatic test_decode();
        @(posedge clk); #1;
        ifa.host_req_i[1] = 1'b1; ifa.host_we_i[1] = 1'b1;
        ifa.host_addr_i[1] = 32'h0002_0004; ifa.host_wdata_i[1] = 32'hCAFE_F00D;
        @(negedge clk);
        n_total++; if (pack3(ifa.host_gnt_o) !== 3'b010)
            $display("FAIL dec_wr_gnt: got %b, expected 010", pack3(ifa.host_gnt_o)); else n_pass++;
        n_total++; if (pack2(ifa.device_req_o) !== 2'b10)
            $display("FAIL dec_wr_dev_req: got %b, expected 10", pack2(ifa.device_req_o)); else n_pass++;
        n_total++; if (ifa.device_addr_o[1] !== 32'h0002_0004 || ifa.device_wdata_o[1] !== 32'hCAFE_F00D || ifa.device_we_o[1] !== 1'b1)
            $display("FAIL dec_wr_fwd: got %h/%h/%b, expected 00020004/cafef00d/1", ifa.device_addr_o[1], ifa.device_wdata_o[1], ifa.device_we_o[1]); else n_pass++;
        n_total++; if (ifa.device_addr_o[0] !== 32'h0 || ifa.device_wdata_o[0] !== 32'h0)
            $display("FAIL dec_unsel_zero: got %h/%h, expected 0/0", ifa.device_addr_o[0], ifa.device_wdata_o[0]); else n_pass++;
        @(posedge clk); #1;
        ifa.host_req_i[1] = 1'b0; ifa.host_we_i[1] = 1'b0;
        ifa.host_req_i[0] = 1'b1; ifa.host_addr_i[0] = 32'h0002_0004;
        @(negedge clk);
        n_total++; if (pack3(ifa.host_rvalid_o) !== 3'b010)
            $display("FAIL dec_wr_rvalid: got %b, expected 010", pack3(ifa.host_rvalid_o)); else n_pass++;
        @(posedge clk); #1;
        ifa.host_addr_i[0] = 32'h0000_FFFC;
        @(negedge clk);
        n_total++; if (pack2(ifa.device_req_o) !== 2'b01)
            $display("FAIL dec_rd_dev0: got %b, expected 01", pack2(ifa.device_req_o)); else n_pass++;
        n_total++; if (pack3(ifa.host_rvalid_o) !== 3'b001 || ifa.host_rdata_o[0] !== 32'hCAFE_F00D)
            $display("FAIL dec_readback: got %b/%h, expected 001/cafef00d", pack3(ifa.host_rvalid_o), ifa.host_rdata_o[0]); else n_pass++;
        @(posedge clk); #1;
        ifa.host_req_i[0] = 1'b0;
        @(negedge clk);
        n_total++; if (pack3(ifa.host_rvalid_o) !== 3'b001 || ifa.host_rdata_o[0] !== 32'hD000_00FF)
            $display("FAIL dec_rd_dev0_data: got %b/%h, expected 001/d00000ff", pack3(ifa.host_rvalid_o), ifa.host_rdata_o[0]); else n_pass++;
    endtask

    task automatic test_unmapped();
        @(posedge clk); #1;
        ifa.host_req_i[2] = 1'b1; ifa.host_addr_i[2] = 32'h4000_0000;
        @(negedge clk);
        n_total++; if (pack3(ifa.host_gnt_o) !== 3'b100)
            $display("FAIL unm_gnt: got %b, expected 100", pack3(ifa.host_gnt_o)); else n_pass++;
        n_total++; if (pack2(ifa.device_req_o) !== 2'b00)
            $display("FAIL unm_dev_req: got %b, expected 00", pack2(ifa.device_req_o)); else n_pass++;
        @(posedge clk); #1;
        ifa.host_req_i[2] = 1'b0;
        @(negedge clk);
        n_total++; if (pack3(ifa.host_rvalid_o) !== 3'b100 || ifa.host_err_o[2] !== 1'b1 || ifa.host_rdata_o[2] !== 32'h0)
            $display("FAIL unm_rsp: got %b/%b/%h, expected 100/1/0", pack3(ifa.host_rvalid_o), ifa.host_err_o[2], ifa.host_rdata_o[2]); else n_pass++;
        n_total++; if (ifa.host_err_o[0] !== 1'b0 || ifa.host_rdata_o[0] !== 32'h0 || ifa.busy_o !== 1'b1)
            $display("FAIL unm_others: got %b/%h/%b, expected 0/0/1", ifa.host_err_o[0], ifa.host_rdata_o[0], ifa.busy_o); else n_pass++;
        @(negedge clk);
        n_total++; if (pack3(ifa.host_rvalid_o) !== 3'b000 || ifa.busy_o !== 1'b0)
            $display("FAIL unm_single: got %b/%b, expected 000/0", pack3(ifa.host_rvalid_o), ifa.busy_o); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int         n_g = 0;
        int         n_r = 0;
        logic [2:0] g;
        logic [2:0] rv;
        logic       in_rsp;
        @(posedge clk); #1;
        ifa.host_req_i[2] = 1'b1; ifa.host_addr_i[2] = 32'h200;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            g      = pack3(ifa.host_gnt_o);
            rv     = pack3(ifa.host_rvalid_o);
            in_rsp = (c >= 1 && c <= 8);
            if (g[2])  n_g++;
            if (rv[2]) n_r++;
            n_total++; if (g !== ((c < 8) ? 3'b100 : 3'b000))
                $display("FAIL b2b_gnt[%0d]: got %b, expected %b", c, g, (c < 8) ? 3'b100 : 3'b000); else n_pass++;
            n_total++; if (rv !== (in_rsp ? 3'b100 : 3'b000))
                $display("FAIL b2b_rvalid[%0d]: got %b, expected %b", c, rv, in_rsp ? 3'b100 : 3'b000); else n_pass++;
            n_total++; if (ifa.busy_o !== in_rsp)
                $display("FAIL b2b_busy[%0d]: got %b, expected %b", c, ifa.busy_o, in_rsp); else n_pass++;
            if (in_rsp) begin
                n_total++; if (ifa.host_rdata_o[2] !== 32'hD000_0080 + 32'(c - 1))
                    $display("FAIL b2b_rdata[%0d]: got %h, expected %h", c, ifa.host_rdata_o[2], 32'hD000_0080 + 32'(c - 1)); else n_pass++;
            end
            @(posedge clk); #1;
            if (c < 7) ifa.host_addr_i[2] = 32'h200 + 32'(4 * (c + 1));
            else       ifa.host_req_i[2]  = 1'b0;
        end
        n_total++; if (n_g !== 8 || n_r !== 8)
            $display("FAIL b2b_counts: got %0d grants/%0d rvalids, expected 8/8", n_g, n_r); else n_pass++;
    endtask

    initial begin
        idle_all();
        ifa.cfg_device_addr_base_i[0] = 32'h0000_0000; ifa.cfg_device_addr_mask_i[0] = 32'hFFFF_0000;
        ifa.cfg_device_addr_base_i[1] = 32'h0002_0000; ifa.cfg_device_addr_mask_i[1] = 32'hFFFF_0000;
        ifb.cfg_device_addr_base_i[0] = 32'h0000_0000; ifb.cfg_device_addr_mask_i[0] = 32'hFFFF_0000;
        ifb.cfg_device_addr_base_i[1] = 32'h0002_0000; ifb.cfg_device_addr_mask_i[1] = 32'hFFFF_0000;
        test_reset();
        test_fixed_priority();
        test_round_robin();
        test_decode();
        test_unmapped();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/bus_host_arbiter.md
Name: bus_host_arbiter

Overview:
- Shared-bus controller for the simulation and compliance top levels.
- Arbitrates between NrHosts bus hosts (test utility, core data port, core instruction port) for a single-issue path to NrDevices memory-mapped devices (RAM, test utility).
- Decodes the address against base/mask pairs, issues one request per cycle, and routes each one-cycle-latency device response back to the originating host.
- Unmapped accesses get a synthesised error response.

Parameters:
- NrHosts, 3, number of requesting hosts; index 0 is highest fixed priority.
- NrDevices, 2, number of target devices.
- DataWidth, 32, data bus width.
- AddressWidth, 32, address bus width.
- RoundRobin, 1'b0, 0 = fixed priority by host index; 1 = round-robin starting after last granted host.

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  asynchronous active-low reset
- host_req_i  input  1 x NrHosts (unpacked)  host request
- host_gnt_o  output  1 x NrHosts  grant, same cycle as accepted request
- host_addr_i  input  AddressWidth x NrHosts  byte address
- host_we_i  input  1 x NrHosts  write enable
- host_be_i  input  DataWidth/8 x NrHosts  byte enables
- host_wdata_i  input  DataWidth x NrHosts  write data
- host_rvalid_o  output  1 x NrHosts  response valid
- host_rdata_o  output  DataWidth x NrHosts  read data
- host_err_o  output  1 x NrHosts  response error
- device_req_o  output  1 x NrDevices  device request
- device_addr_o, device_we_o, device_be_o, device_wdata_o  output  per device  forwarded from the granted host
- device_rvalid_i  input  1 x NrDevices  device response valid
- device_rdata_i  input  DataWidth x NrDevices  device read data
- device_err_i  input  1 x NrDevices  device error
- cfg_device_addr_base_i  input  AddressWidth x NrDevices  base address
- cfg_device_addr_mask_i  input  AddressWidth x NrDevices  address mask
- busy_o  output  1  a response is outstanding this cycle

Behaviour:
- Reset is asynchronous, active-low. All outputs are 0 out of reset; rr_ptr_q = NrHosts-1; no response pending.
- Arbitration (combinational) picks at most one host per cycle.
  - Fixed mode: lowest requesting index wins.
  - Round-robin mode: first requester at index rr_ptr_q+1 upward, wrapping at NrHosts.
  - rr_ptr_q updates to the winner on grant only. With no request it holds.
- Address decode: device d matches when (addr & mask[d]) == base[d]. With multiple matches, the lowest d wins. With no match, the access is marked unmapped.
- Grant cycle N:
  - host_gnt_o[winner]=1.
  - If mapped: device_req_o[d]=1 with addr/we/be/wdata forwarded. All other device_req_o are 0. device_addr_o/we/be/wdata for non-selected devices are 0.
- Response tracking flops: rsp_valid_q, rsp_host_q, rsp_dev_q, rsp_unmapped_q, written on every grant.
- Cycle N+1:
  - host_rvalid_o[rsp_host_q]=1.
  - rdata/err come from device_*_i[rsp_dev_q].
  - If unmapped: rdata=0, err=1.
  - Devices without an error output tie device_err_i low.
- Response data is forwarded combinationally; there is no extra register stage.
- Pipelined back-to-back operation: a new grant in cycle N+1 is allowed concurrently with the response for N. Throughput is one transaction per cycle.
- Writes also produce rvalid in N+1 (rdata is don't-care, driven as device data).
- host_rdata_o/host_err_o for non-responding hosts are driven 0.
- A device_rvalid_i not matching an outstanding request is ignored.
- An assertion flags a missing device_rvalid_i in N+1 for a mapped request.
- Reset mid-transaction: the pending response is dropped. No rvalid follows reset deassertion.
- busy_o = rsp_valid_q.

Decomposition:
- A shared package holds bus_arb_mode_e (FixedPrio, RoundRobin) and a response-tag struct (valid, host index, device index, unmapped).
- One natural sub-module: bus_rr_arb, a pure combinational priority/round-robin picker with a one-hot grant and index output, plus ptr_i input.
- Decode and response routing stay in the top module.

Test Plan:
- Reset: assert rst_ni=0 mid-request -> all gnt/rvalid/device_req are 0. After release, rr_ptr_q=NrHosts-1 and no stray rvalid.
- Fixed priority: hosts 0,1,2 request simultaneously, addr 0x100 -> gnt order 0,1,2 over three cycles. rvalid to each exactly one cycle after its grant. rdata matches RAM.
- Round-robin (RoundRobin=1): hosts 1 and 2 hold requests for 4 cycles -> grants alternate 1,2,1,2.
- Decode: host 1 writes 0x20004 -> device_req_o[1]=1, device_req_o[0]=0. Read 0x0000_FFFC -> device 0 selected.
- Unmapped: host 2 reads 0x4000_0000 -> gnt in N. In N+1: rvalid=1, err=1, rdata=0. No device_req asserted.
- Back-to-back: host 2 issues reads every cycle for 8 cycles -> 8 grants and 8 rvalids on consecutive cycles; busy_o high from cycle 2 through 9.
